// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Included by the starvation counter and the top-level arbiter.
package dmem_arb_pkg;

    localparam int STARVE_W             = 8;
    localparam int STARVE_LIMIT_DEFAULT = 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_C    = 2'd1,
        OWN_D    = 2'd2
    } rd_owner_t;

    // Out-of-range limits are pulled into 1..255 so the counter always has a reachable ceiling.
    function automatic logic [STARVE_W-1:0] starve_limit_cnt(input int lim);
        if (lim < 1) begin
            return STARVE_W'(1);
        end else if (lim > 255) begin
            return STARVE_W'(255);
        end
        return STARVE_W'(lim);
    endfunction

endpackage

// File: rtl/dmem_arb_starve_cnt.sv
// Counts consecutive cycles in which the loader requested but was denied.
// It saturates at the limit, where it forces the loader through.
module dmem_arb_starve_cnt
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                d_req,
    input  logic                d_gnt,
    output logic [STARVE_W-1:0] cnt,
    output logic                starved
);

    localparam logic [STARVE_W-1:0] LIMIT = starve_limit_cnt(STARVE_LIMIT);

    logic [STARVE_W-1:0] cnt_q;
    logic [STARVE_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (d_gnt || !d_req) begin
            cnt_d = '0;
        end else if (cnt_q >= LIMIT) begin
            cnt_d = LIMIT;
        end else begin
            cnt_d = cnt_q + STARVE_W'(1);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt     = cnt_q;
    assign starved = d_req & (cnt_q == LIMIT);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Fixed-priority arbiter for the CPU (C) and loader (D) ports of the single-ported data memory.
// The loader gets a guaranteed slot through a starvation counter.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic          clock,
    input  logic          resetn,

    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_stall,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,

    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,

    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,

    output logic          starved
);

    localparam logic [STARVE_W-1:0] LIMIT = starve_limit_cnt(STARVE_LIMIT);

    logic [STARVE_W-1:0] cnt;
    logic                d_force;
    rd_owner_t           rd_owner_q;
    rd_owner_t           rd_owner_d;

    dmem_arb_starve_cnt #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve_cnt (
        .clock  (clock),
        .resetn (resetn),
        .d_req  (d_req),
        .d_gnt  (d_gnt),
        .cnt    (cnt),
        .starved(starved)
    );

    assign d_force = d_req & (cnt == LIMIT);

    // Grants are held off while reset is asserted, even with requests pending.
    always_comb begin
        c_gnt = 1'b0;
        d_gnt = 1'b0;
        if (resetn) begin
            if (d_force) begin
                d_gnt = 1'b1;
            end else if (c_req) begin
                c_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end
        end
    end

    assign c_stall = c_req & ~c_gnt;

    always_comb begin
        m_en    = c_gnt | d_gnt;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        if (c_gnt) begin
            m_we    = c_we;
            m_addr  = c_addr;
            m_wdata = c_wdata;
        end else if (d_gnt) begin
            m_we    = d_we;
            m_addr  = d_addr;
            m_wdata = d_wdata;
        end
    end

    // Read-return tracker: remembers which port owns the data arriving next cycle.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rd_owner_q <= OWN_NONE;
        end else begin
            rd_owner_q <= rd_owner_d;
        end
    end

    always_comb begin
        rd_owner_d = OWN_NONE;
        if (c_gnt && !c_we) begin
            rd_owner_d = OWN_C;
        end else if (d_gnt && !d_we) begin
            rd_owner_d = OWN_D;
        end
    end

    always_comb begin
        c_rvalid = (rd_owner_q == OWN_C);
        d_rvalid = (rd_owner_q == OWN_D);
    end

    assign c_rdata = m_rdata;
    assign d_rdata = m_rdata;

endmodule
